// File: rtl/ahb_addr_decoder_if.sv
// AHB decoder bus bundle: address phase in, per-slave responses in, muxed response out.
interface ahb_addr_decoder_if #(
  parameter int unsigned SLAVE_NUM = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IDX_W     = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
);
  logic [ADDR_W-1:0]           HADDR;
  logic [1:0]                  HTRANS;
  logic [SLAVE_NUM*DATA_W-1:0] HRDATA_S;
  logic [SLAVE_NUM-1:0]        HREADYOUT_S;
  logic [SLAVE_NUM-1:0]        HRESP_S;
  logic [SLAVE_NUM-1:0]        HSEL;
  logic [DATA_W-1:0]           HRDATA;
  logic                        HREADY;
  logic                        HRESP;
  logic [IDX_W-1:0]            DATA_SEL;

  // Decoder side
  modport slave (
    input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HSEL, HRDATA, HREADY, HRESP, DATA_SEL
  );

  // Surrounding fabric side (master plus slaves)
  modport master (
    output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HSEL, HRDATA, HREADY, HRESP, DATA_SEL
  );
endinterface

// File: rtl/ahb_addr_decoder.sv
// AHB address decoder with data-phase response mux and built-in default slave.
module ahb_addr_decoder #(
  parameter int unsigned       SLAVE_NUM   = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       REGION_BITS = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_addr_decoder_if.slave bus
);

  localparam int unsigned IDX_W  = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int unsigned HI_LSB = REGION_BITS + IDX_W;

  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dstate_e;

  dstate_e          state_q, state_d;
  logic             dp_valid_q, dp_valid_d;
  logic [IDX_W-1:0] data_sel_q, data_sel_d;

  logic [IDX_W-1:0]     slot_c;
  logic                 mapped_c;
  logic                 active_c;
  logic                 err_req_c;
  logic [SLAVE_NUM-1:0] hsel_c;
  logic                 hready_c;
  logic                 hresp_c;
  logic [DATA_W-1:0]    hrdata_c;

  // Address-phase decode: window match above the slot field, slot must name a real slave
  always_comb begin
    slot_c    = bus.HADDR[REGION_BITS +: IDX_W];
    mapped_c  = ((bus.HADDR >> HI_LSB) == (BASE_ADDR >> HI_LSB)) &&
                (32'(slot_c) < SLAVE_NUM);
    active_c  = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
    err_req_c = !mapped_c && active_c;
    hsel_c    = '0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      hsel_c[i] = mapped_c && (slot_c == IDX_W'(i));
    end
  end

  // Data-phase response mux, default-slave outputs and next-state logic
  always_comb begin
    hready_c   = 1'b1;
    hresp_c    = 1'b0;
    hrdata_c   = '0;
    state_d    = state_q;
    dp_valid_d = dp_valid_q;
    data_sel_d = data_sel_q;

    if (dp_valid_q) begin
      for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
        if (data_sel_q == IDX_W'(i)) begin
          hready_c = bus.HREADYOUT_S[i];
          hresp_c  = bus.HRESP_S[i];
          hrdata_c = bus.HRDATA_S[i*DATA_W +: DATA_W];
        end
      end
    end else begin
      case (state_q)
        D_ERR1: begin
          hready_c = 1'b0;
          hresp_c  = 1'b1;
        end
        D_ERR2: hresp_c = 1'b1;
        default: ;
      endcase
    end

    // A transfer is accepted only on a cycle where HREADY is high
    if (hready_c) begin
      dp_valid_d = mapped_c;
      if (mapped_c) data_sel_d = slot_c;
    end

    // Default-slave state tracks the two-cycle ERROR response of unmapped transfers
    case (state_q)
      D_IDLE:  state_d = (hready_c && err_req_c) ? D_ERR1 : D_IDLE;
      D_ERR1:  state_d = D_ERR2;
      D_ERR2:  state_d = (hready_c && err_req_c) ? D_ERR1 : D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  // Data-phase and default-slave state registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= D_IDLE;
      dp_valid_q <= 1'b0;
      data_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= dp_valid_d;
      data_sel_q <= data_sel_d;
    end
  end

  assign bus.HSEL     = hsel_c;
  assign bus.HREADY   = hready_c;
  assign bus.HRESP    = hresp_c;
  assign bus.HRDATA   = hrdata_c;
  assign bus.DATA_SEL = data_sel_q;

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// Directed bench for ahb_addr_decoder: 4-slave table run plus a 3-slave reset corner.
module tb_ahb_addr_decoder;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0001;
  localparam logic [31:0] W2 = 32'h3333_0002;
  localparam logic [31:0] W3 = 32'h4444_0003;

  typedef struct {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [3:0]  rdy;
    logic [3:0]  resp;
    logic [3:0]  hsel;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [1:0]  sel;
  } vec_t;

  logic clk;
  logic rst_n;
  logic rst3_n;
  int   checks;
  int   errors;

  ahb_addr_decoder_if #(.SLAVE_NUM(4), .IDX_W(2)) bus4 ();
  ahb_addr_decoder_if #(.SLAVE_NUM(3), .IDX_W(2)) bus3 ();

  ahb_addr_decoder #(.SLAVE_NUM(4)) u_dut4 (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus4.slave)
  );

  ahb_addr_decoder #(.SLAVE_NUM(3)) u_dut3 (
    .HCLK    (clk),
    .HRESETn (rst3_n),
    .bus     (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle on the 4-slave DUT, check outputs mid-cycle, then advance past the edge
  task automatic run_vec(input vec_t v, input string tag);
    bus4.HADDR       = v.haddr;
    bus4.HTRANS      = v.htrans;
    bus4.HREADYOUT_S = v.rdy;
    bus4.HRESP_S     = v.resp;
    @(negedge clk);
    check({tag, " hsel"},     32'(bus4.HSEL),     32'(v.hsel));
    check({tag, " hready"},   32'(bus4.HREADY),   32'(v.hready));
    check({tag, " hresp"},    32'(bus4.HRESP),    32'(v.hresp));
    check({tag, " hrdata"},   bus4.HRDATA,        v.hrdata);
    check({tag, " data_sel"}, 32'(bus4.DATA_SEL), 32'(v.sel));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{32'h0000_2010, NONSEQ, 4'hF, 4'h0, 4'b0100, 1'b1, 1'b0, 32'h0, 2'd0};
    vecs[1]  = '{32'h0000_1004, NONSEQ, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, W2,    2'd2};
    vecs[2]  = '{32'h0000_4000, NONSEQ, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, W1,    2'd1};
    vecs[3]  = '{32'h0000_0000, IDLE,   4'hF, 4'h0, 4'b0001, 1'b0, 1'b1, 32'h0, 2'd1};
    vecs[4]  = '{32'h0000_0000, IDLE,   4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, 32'h0, 2'd1};
    vecs[5]  = '{32'h0001_0000, IDLE,   4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, W0,    2'd0};
    vecs[6]  = '{32'h0000_3000, SEQ,    4'hF, 4'h0, 4'b1000, 1'b1, 1'b0, 32'h0, 2'd0};
    vecs[7]  = '{32'h0000_8000, SEQ,    4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, W3,    2'd3};
    vecs[8]  = '{32'h0000_8004, SEQ,    4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0, 2'd3};
    vecs[9]  = '{32'h0000_8004, SEQ,    4'hF, 4'h0, 4'b0000, 1'b1, 1'b1, 32'h0, 2'd3};
    vecs[10] = '{32'h0000_8008, SEQ,    4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0, 2'd3};
    vecs[11] = '{32'h0000_2000, NONSEQ, 4'hF, 4'h0, 4'b0100, 1'b1, 1'b1, 32'h0, 2'd3};
    vecs[12] = '{32'h0000_0000, IDLE,   4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, W2,    2'd2};
    vecs[13] = '{32'h0001_0000, BUSY,   4'hF, 4'h1, 4'b0000, 1'b1, 1'b1, W0,    2'd0};
    vecs[14] = '{32'h0000_0000, IDLE,   4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 32'h0, 2'd0};

    // Reset state, with HSEL still decoding while reset is held
    rst_n            = 1'b0;
    rst3_n           = 1'b0;
    bus4.HRDATA_S    = {W3, W2, W1, W0};
    bus4.HADDR       = 32'h0000_2010;
    bus4.HTRANS      = NONSEQ;
    bus4.HREADYOUT_S = 4'hF;
    bus4.HRESP_S     = 4'h0;
    bus3.HRDATA_S    = {W2, W1, W0};
    bus3.HADDR       = 32'h0001_0000;
    bus3.HTRANS      = IDLE;
    bus3.HREADYOUT_S = 3'b111;
    bus3.HRESP_S     = 3'b000;
    #2;
    check("reset hsel",     32'(bus4.HSEL),     32'h4);
    check("reset hready",   32'(bus4.HREADY),   32'h1);
    check("reset hresp",    32'(bus4.HRESP),    32'h0);
    check("reset hrdata",   bus4.HRDATA,        32'h0);
    check("reset data_sel", 32'(bus4.DATA_SEL), 32'h0);

    bus4.HADDR  = 32'h0001_0000;
    bus4.HTRANS = IDLE;
    @(negedge clk);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Slave 1 inserts three wait states while the next address points at slave 3
    run_vec('{32'h0000_1000, NONSEQ, 4'hF,    4'h0, 4'b0010, 1'b1, 1'b0, W0,    2'd0}, "ws0");
    run_vec('{32'h0000_3000, NONSEQ, 4'b1101, 4'h0, 4'b1000, 1'b0, 1'b0, W1,    2'd1}, "ws1");
    run_vec('{32'h0000_3004, NONSEQ, 4'b1101, 4'h0, 4'b1000, 1'b0, 1'b0, W1,    2'd1}, "ws2");
    run_vec('{32'h0000_3008, NONSEQ, 4'b1101, 4'h0, 4'b1000, 1'b0, 1'b0, W1,    2'd1}, "ws3");
    run_vec('{32'h0000_3008, NONSEQ, 4'hF,    4'h0, 4'b1000, 1'b1, 1'b0, W1,    2'd1}, "ws4");
    run_vec('{32'h0000_0000, IDLE,   4'hF,    4'h0, 4'b0001, 1'b1, 1'b0, W3,    2'd3}, "ws5");

    // Three slaves: slot 3 is unmapped, reset cuts the ERROR response short
    bus3.HADDR  = 32'h0000_3000;
    bus3.HTRANS = NONSEQ;
    @(negedge clk);
    check("s3 unmapped hsel",  32'(bus3.HSEL),   32'h0);
    check("s3 pre hready",     32'(bus3.HREADY), 32'h1);
    @(posedge clk);
    #1;
    bus3.HADDR  = 32'h0000_2000;
    bus3.HTRANS = IDLE;
    @(negedge clk);
    check("s3 err1 hready",    32'(bus3.HREADY), 32'h0);
    check("s3 err1 hresp",     32'(bus3.HRESP),  32'h1);
    #1;
    rst3_n = 1'b0;
    #1;
    check("s3 rst hready",     32'(bus3.HREADY), 32'h1);
    check("s3 rst hresp",      32'(bus3.HRESP),  32'h0);
    check("s3 rst hrdata",     bus3.HRDATA,      32'h0);
    check("s3 rst hsel",       32'(bus3.HSEL),   32'h4);
    @(posedge clk);
    #1;
    rst3_n = 1'b1;
    @(negedge clk);
    check("s3 post hready",    32'(bus3.HREADY), 32'h1);
    check("s3 post hresp",     32'(bus3.HRESP),  32'h0);
    @(posedge clk);
    #1;
    bus3.HADDR = 32'h0001_0000;
    @(negedge clk);
    check("s3 slave2 sel",     32'(bus3.DATA_SEL), 32'h2);
    check("s3 slave2 hrdata",  bus3.HRDATA,        W2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
